// File: rtl/draw_sequencer.sv
// draw_sequencer: command-driven pixel engine for a 160x120, 3-bit-colour framebuffer.
// Accepts one CLEAR / FILL / LINE / NOP command at a time and emits one registered
// (x, y, color, plot) pixel per clock, followed by a one-cycle done pulse.
module draw_sequencer #(
  parameter int XRES = 160,
  parameter int YRES = 120
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [7:0] cmd_x0,
  input  logic [6:0] cmd_y0,
  input  logic [7:0] cmd_x1,
  input  logic [6:0] cmd_y1,
  input  logic [2:0] cmd_color,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] color,
  output logic       plot,
  output logic       busy,
  output logic       done
);

  localparam logic [7:0] X_MAX = 8'(XRES - 1);
  localparam logic [6:0] Y_MAX = 7'(YRES - 1);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_LINE, S_FIN} state_t;

  state_t state_q, state_d;

  logic [7:0]        x_d;
  logic [6:0]        y_d;
  logic [2:0]        color_d;
  logic              plot_d, busy_d, done_d;

  // Walking cursor, line end point and Bresenham terms.
  logic [7:0]        cx_q, cx_d, ex_q, ex_d;
  logic [6:0]        cy_q, cy_d, ey_q, ey_d;
  logic signed [10:0] dx_q, dx_d, dy_q, dy_d, err_q, err_d;
  logic              sx_neg_q, sx_neg_d, sy_neg_q, sy_neg_d;
  logic              fill_q, fill_d;
  logic [2:0]        lcolor_q, lcolor_d;

  // Setup terms derived from the raw command, and the per-step decisions.
  logic [7:0]        x0c, x1c;
  logic [6:0]        y0c, y1c;
  logic signed [10:0] xdiff, ydiff, dx_init, dy_init, e2;
  logic              step_x, step_y;

  assign cmd_ready = (state_q == S_IDLE);

  // Clamp the line operands and derive the Bresenham setup and step decisions.
  always_comb begin
    x0c     = (cmd_x0 > X_MAX) ? X_MAX : cmd_x0;
    x1c     = (cmd_x1 > X_MAX) ? X_MAX : cmd_x1;
    y0c     = (cmd_y0 > Y_MAX) ? Y_MAX : cmd_y0;
    y1c     = (cmd_y1 > Y_MAX) ? Y_MAX : cmd_y1;
    xdiff   = $signed({3'b000, x1c}) - $signed({3'b000, x0c});
    ydiff   = $signed({4'b0000, y1c}) - $signed({4'b0000, y0c});
    dx_init = xdiff[10] ? -xdiff : xdiff;
    dy_init = ydiff[10] ? ydiff : -ydiff;
    e2      = err_q <<< 1;
    step_x  = (e2 >= dy_q);
    step_y  = (e2 <= dx_q);
  end

  // Next-state and next-output logic for the command FSM.
  always_comb begin
    // NOTE: every variable gets a default here so no path leaves one unassigned,
    // which would otherwise infer a latch.
    state_d  = state_q;
    x_d      = x;
    y_d      = y;
    color_d  = color;
    plot_d   = 1'b0;
    busy_d   = busy;
    done_d   = 1'b0;
    cx_d     = cx_q;
    cy_d     = cy_q;
    ex_d     = ex_q;
    ey_d     = ey_q;
    dx_d     = dx_q;
    dy_d     = dy_q;
    err_d    = err_q;
    sx_neg_d = sx_neg_q;
    sy_neg_d = sy_neg_q;
    fill_d   = fill_q;
    lcolor_d = lcolor_q;

    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          busy_d   = 1'b1;
          fill_d   = (cmd_op == 2'd1);
          lcolor_d = cmd_color;
          ex_d     = x1c;
          ey_d     = y1c;
          dx_d     = dx_init;
          dy_d     = dy_init;
          err_d    = dx_init + dy_init;
          sx_neg_d = !(x0c < x1c);
          sy_neg_d = !(y0c < y1c);
          unique case (cmd_op)
            2'd0, 2'd1: begin
              cx_d    = 8'd0;
              cy_d    = 7'd0;
              state_d = S_SCAN;
            end
            2'd2: begin
              cx_d    = x0c;
              cy_d    = y0c;
              state_d = S_LINE;
            end
            default: state_d = S_FIN;
          endcase
        end
      end

      S_SCAN: begin
        x_d     = cx_q;
        y_d     = cy_q;
        color_d = fill_q ? cy_q[2:0] : 3'd0;
        plot_d  = 1'b1;
        if (cx_q == X_MAX) begin
          cx_d = 8'd0;
          if (cy_q == Y_MAX) state_d = S_FIN;
          else               cy_d    = cy_q + 7'd1;
        end else begin
          cx_d = cx_q + 8'd1;
        end
      end

      S_LINE: begin
        x_d     = cx_q;
        y_d     = cy_q;
        color_d = lcolor_q;
        plot_d  = 1'b1;
        if (cx_q == ex_q && cy_q == ey_q) begin
          state_d = S_FIN;
        end else begin
          err_d = err_q + (step_x ? dy_q : 11'sd0) + (step_y ? dx_q : 11'sd0);
          if (step_x) cx_d = sx_neg_q ? cx_q - 8'd1 : cx_q + 8'd1;
          if (step_y) cy_d = sy_neg_q ? cy_q - 7'd1 : cy_q + 7'd1;
        end
      end

      S_FIN: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State, datapath and output registers; reset aborts any command in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      x        <= 8'd0;
      y        <= 7'd0;
      color    <= 3'd0;
      plot     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      cx_q     <= 8'd0;
      cy_q     <= 7'd0;
      ex_q     <= 8'd0;
      ey_q     <= 7'd0;
      dx_q     <= 11'sd0;
      dy_q     <= 11'sd0;
      err_q    <= 11'sd0;
      sx_neg_q <= 1'b0;
      sy_neg_q <= 1'b0;
      fill_q   <= 1'b0;
      lcolor_q <= 3'd0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge
      // values, independent of statement order.
      state_q  <= state_d;
      x        <= x_d;
      y        <= y_d;
      color    <= color_d;
      plot     <= plot_d;
      busy     <= busy_d;
      done     <= done_d;
      cx_q     <= cx_d;
      cy_q     <= cy_d;
      ex_q     <= ex_d;
      ey_q     <= ey_d;
      dx_q     <= dx_d;
      dy_q     <= dy_d;
      err_q    <= err_d;
      sx_neg_q <= sx_neg_d;
      sy_neg_q <= sy_neg_d;
      fill_q   <= fill_d;
      lcolor_q <= lcolor_d;
    end
  end

endmodule

// File: doc/draw_sequencer.md
Name: draw_sequencer

Overview:
Command-driven pixel engine that produces the plot stream for the 160x120, 3-bit-colour VGA framebuffer adapter. It accepts one draw command at a time: CLEAR (full-screen blank), FILL (full-screen colour bands) or LINE (Bresenham line, all octants). It emits one registered (x, y, color, plot) pixel per clock and signals completion. It sits directly upstream of the VGA adapter's write port and downstream of the user/command front end.

Parameters:
XRES, 160, horizontal pixel count; x range is 0..XRES-1
YRES, 120, vertical pixel count; y range is 0..YRES-1

Ports:
clk  input  1  system clock; all logic on the rising edge
reset  input  1  asynchronous, active-high reset
cmd_valid  input  1  command present
cmd_ready  output  1  engine can accept a command
cmd_op  input  2  0=CLEAR, 1=FILL, 2=LINE, 3=NOP
cmd_x0  input  8  line start x
cmd_y0  input  7  line start y
cmd_x1  input  8  line end x
cmd_y1  input  7  line end y
cmd_color  input  3  line colour (LINE only)
x  output  8  pixel x
y  output  7  pixel y
color  output  3  pixel colour
plot  output  1  write strobe; x/y/color valid when high
busy  output  1  command in progress
done  output  1  one-cycle pulse at command completion

Behaviour:
- Reset (async, active-high): state IDLE; x=0, y=0, color=0, plot=0, busy=0, done=0; cmd_ready=1 once reset deasserts.
- All outputs are registered; cmd_ready = (state==IDLE).
- States: IDLE, SCAN, LINE, FIN.
- IDLE: a command is accepted when cmd_valid && cmd_ready. The operands are latched on that edge and busy goes to 1 on the same edge. cmd_valid outside IDLE is ignored; there is no queuing.
  - op 0/1 -> SCAN.
  - op 2 -> LINE.
  - op 3 -> FIN, with no plots.
- Latency: the first plot=1 appears on the clock edge after acceptance.
- SCAN:
  - Emits every pixel in raster order, one per cycle, plot=1 continuously.
  - Order is (0,0), (1,0) ... (XRES-1,0), (0,1) ... (XRES-1,YRES-1): x wraps at XRES-1 and y increments.
  - Exactly XRES*YRES = 19200 plots.
  - color = 0 for CLEAR; color = y[2:0] (y mod 8) for FILL.
  - After (XRES-1,YRES-1) -> FIN.
- LINE:
  - Coordinates are clamped at acceptance: x values >= XRES become XRES-1, y values >= YRES become YRES-1.
  - Setup on acceptance:
    - dx = |x1-x0|, dy = -|y1-y0|.
    - sx = +1 if x0<x1, else -1; sy = +1 if y0<y1, else -1.
    - err = dx+dy.
    - All error arithmetic is 11-bit signed.
  - Each cycle, output (cx, cy, cmd_color) with plot=1.
  - If (cx,cy)==(x1,y1) -> FIN. Otherwise, with e2 = 2*err (from the same err):
    - if e2 >= dy: err += dy, cx += sx;
    - if e2 <= dx: err += dx, cy += sy.
    - Both updates may occur in one cycle.
  - Plot count = max(|x1-x0|, |y1-y0|) + 1. The endpoints are always plotted; x0==x1 && y0==y1 gives exactly one plot.
- FIN:
  - plot=0, done=1 for exactly one cycle, busy=0.
  - Next cycle: IDLE, cmd_ready=1.
  - Minimum command-to-command spacing is therefore the plot count + 2 cycles.
- Outputs while idle: plot=0. x/y/color hold their last values (don't-care).
- Reset mid-command: immediate abort to the reset values. No done pulse. No further plots.
- Coordinates never leave 0..XRES-1 / 0..YRES-1.

Test Plan:
1. Reset, then CLEAR -> 19200 consecutive plot=1 cycles; first (0,0), 160th (159,0), last (159,119); color always 0; done one cycle later; busy low after done.
2. FILL -> color 0 on row 0, 7 on row 7, 0 on row 8, 7 on row 119 (119 mod 8 = 7); 19200 plots.
3. LINE (10,5)->(14,5), color 5 -> plots (10,5), (11,5), (12,5), (13,5), (14,5), all color 5; then done.
4. LINE (20,30)->(17,36) -> 7 plots; first (20,30), last (17,36); y strictly increasing; x non-increasing; no step > 1 in either axis.
5. LINE (50,50)->(50,50) -> exactly 1 plot; LINE (200,127)->(159,119) clamps to a single plot at (159,119).
6. Assert cmd_valid continuously during a CLEAR, then assert reset at pixel 1000 -> cmd_ready stays 0 during the scan; on reset, plot=0 immediately, no done pulse; a LINE issued after release starts cleanly.
